// File: rtl/subleq_mem.sv
// Program memory for a subleq CPU: zeroes itself after reset, accepts a byte-stream program
// load, then serves the CPU read/write ports with a memory-mapped output FIFO.
module subleq_mem #(
  parameter logic [7:0]  OUT_ADDR   = 8'hFF,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic       i_clk,
  input  logic       i_rstn,
  input  logic       i_ld_valid,
  output logic       o_ld_ready,
  input  logic [7:0] i_ld_data,
  input  logic       i_ld_last,
  input  logic [7:0] i_raddr,
  output logic [7:0] o_rdata,
  input  logic [7:0] i_waddr,
  input  logic [7:0] i_wdata,
  input  logic       i_we,
  output logic       o_cpu_rstn,
  output logic       o_out_valid,
  input  logic       i_out_ready,
  output logic [7:0] o_out_data,
  output logic       o_out_overflow
);

  localparam int unsigned PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int unsigned CNT_W = $clog2(FIFO_DEPTH + 1);
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(FIFO_DEPTH);

  typedef enum logic [1:0] {S_CLEAR, S_LOAD, S_RUN} state_t;

  state_t           r_state, w_state_nxt;
  logic [7:0]       r_clr_cnt;
  logic [7:0]       r_ld_ptr;
  logic             r_cpu_rstn;
  logic [7:0]       r_mem [256];

  logic             w_mem_we;
  logic [7:0]       w_mem_addr;
  logic [7:0]       w_mem_data;

  logic [7:0]       r_fifo [FIFO_DEPTH];
  logic [PTR_W-1:0] r_wr_ptr, r_rd_ptr;
  logic [CNT_W-1:0] r_count;
  logic             r_overflow;
  logic             w_push, w_pop, w_full, w_push_ok;

  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) r_state <= S_CLEAR;
    else         r_state <= w_state_nxt;
  end

  // Single write port shared by clear, load and CPU, selected by state.
  always_comb begin
    w_state_nxt = r_state;
    w_mem_we    = 1'b0;
    w_mem_addr  = r_clr_cnt;
    w_mem_data  = 8'h00;
    unique case (r_state)
      S_CLEAR: begin
        w_mem_we = 1'b1;
        if (r_clr_cnt == 8'hFF) w_state_nxt = S_LOAD;
      end
      S_LOAD: begin
        w_mem_we   = i_ld_valid;
        w_mem_addr = r_ld_ptr;
        w_mem_data = i_ld_data;
        if (i_ld_valid && (i_ld_last || r_ld_ptr == 8'hFF)) w_state_nxt = S_RUN;
      end
      S_RUN: begin
        w_mem_we   = i_we;
        w_mem_addr = i_waddr;
        w_mem_data = i_wdata;
      end
      default: w_state_nxt = S_CLEAR;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      r_clr_cnt  <= 8'h00;
      r_ld_ptr   <= 8'h00;
      r_cpu_rstn <= 1'b0;
    end else begin
      if (r_state == S_CLEAR) r_clr_cnt <= r_clr_cnt + 8'h01;
      if (r_state == S_LOAD && i_ld_valid) r_ld_ptr <= r_ld_ptr + 8'h01;
      r_cpu_rstn <= (r_state == S_RUN);
    end
  end

  // Array is not reset; S_CLEAR zeroes it after every reset.
  always_ff @(posedge i_clk) begin
    if (w_mem_we) r_mem[w_mem_addr] <= w_mem_data;
  end

  assign o_rdata    = r_mem[i_raddr];
  assign o_ld_ready = (r_state == S_LOAD);
  assign o_cpu_rstn = r_cpu_rstn;

  assign w_push    = (r_state == S_RUN) && i_we && (i_waddr == OUT_ADDR);
  assign w_full    = (r_count == FULL_CNT);
  assign o_out_valid = (r_count != '0);
  assign w_pop     = o_out_valid && i_out_ready;
  // A pop in the same cycle frees the slot, so a full FIFO still accepts the push.
  assign w_push_ok = w_push && (!w_full || w_pop);
  assign o_out_data = r_fifo[r_rd_ptr];
  assign o_out_overflow = r_overflow;

  always_ff @(posedge i_clk) begin
    if (w_push_ok) r_fifo[r_wr_ptr] <= i_wdata;
  end

  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_count    <= '0;
      r_overflow <= 1'b0;
    end else begin
      if (w_push_ok) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      if (w_pop)     r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      case ({w_push_ok, w_pop})
        2'b10:   r_count <= r_count + CNT_W'(1);
        2'b01:   r_count <= r_count - CNT_W'(1);
        default: r_count <= r_count;
      endcase
      if (w_push && !w_push_ok) r_overflow <= 1'b1;
    end
  end

endmodule

// File: tb/tb_subleq_mem.sv
// Self-checking bench for subleq_mem: clear, load with stall, CPU writes, output FIFO
// overflow / simultaneous push-pop, and asynchronous reset mid-run.
`timescale 1ns/1ps
module tb_subleq_mem;

  logic       i_clk = 1'b0;
  logic       i_rstn = 1'b0;
  logic       i_ld_valid = 1'b0;
  logic       o_ld_ready;
  logic [7:0] i_ld_data = 8'h00;
  logic       i_ld_last = 1'b0;
  logic [7:0] i_raddr = 8'h00;
  logic [7:0] o_rdata;
  logic [7:0] i_waddr = 8'h00;
  logic [7:0] i_wdata = 8'h00;
  logic       i_we = 1'b0;
  logic       o_cpu_rstn;
  logic       o_out_valid;
  logic       i_out_ready = 1'b0;
  logic [7:0] o_out_data;
  logic       o_out_overflow;

  int n_tests = 0;
  int n_fail  = 0;
  logic [7:0] sb_q [$];

  always #5 i_clk = ~i_clk;

  subleq_mem #(.OUT_ADDR(8'hFF), .FIFO_DEPTH(4)) dut (
    .i_clk         (i_clk),
    .i_rstn        (i_rstn),
    .i_ld_valid    (i_ld_valid),
    .o_ld_ready    (o_ld_ready),
    .i_ld_data     (i_ld_data),
    .i_ld_last     (i_ld_last),
    .i_raddr       (i_raddr),
    .o_rdata       (o_rdata),
    .i_waddr       (i_waddr),
    .i_wdata       (i_wdata),
    .i_we          (i_we),
    .o_cpu_rstn    (o_cpu_rstn),
    .o_out_valid   (o_out_valid),
    .i_out_ready   (i_out_ready),
    .o_out_data    (o_out_data),
    .o_out_overflow(o_out_overflow)
  );

  task automatic step();
    @(posedge i_clk);
    #1;
  endtask

  task automatic read_mem(input logic [7:0] a, output logic [7:0] d);
    i_raddr = a;
    #1;
    d = o_rdata;
  endtask

  // Runs 256 clock edges after reset release; counts samples where o_ld_ready rose early.
  task automatic run_clear(output int bad, output logic rdy_end);
    bad = 0;
    for (int i = 0; i < 256; i++) begin
      step();
      if (i < 255 && o_ld_ready !== 1'b0) bad++;
    end
    rdy_end = o_ld_ready;
  endtask

  task automatic test_reset();
    int bad;
    int nz;
    logic rdy;
    logic [7:0] d;
    i_rstn = 1'b0; i_ld_valid = 1'b1; i_ld_data = 8'hAA;
    step(); step();
    n_tests++; if (o_ld_ready !== 1'b0) begin n_fail++; $display("FAIL rst_ld_ready: got %b want 0", o_ld_ready); end
    n_tests++; if (o_cpu_rstn !== 1'b0) begin n_fail++; $display("FAIL rst_cpu_rstn: got %b want 0", o_cpu_rstn); end
    n_tests++; if (o_out_valid !== 1'b0) begin n_fail++; $display("FAIL rst_out_valid: got %b want 0", o_out_valid); end
    n_tests++; if (o_out_overflow !== 1'b0) begin n_fail++; $display("FAIL rst_overflow: got %b want 0", o_out_overflow); end
    i_rstn = 1'b1;
    run_clear(bad, rdy);
    i_ld_valid = 1'b0;
    n_tests++; if (bad !== 0) begin n_fail++; $display("FAIL clear_ready_low: early ready samples %0d want 0", bad); end
    n_tests++; if (rdy !== 1'b1) begin n_fail++; $display("FAIL clear_to_load: ready %b want 1", rdy); end
    nz = 0;
    for (int a = 0; a < 256; a++) begin
      read_mem(8'(a), d);
      if (d !== 8'h00) nz++;
    end
    n_tests++; if (nz !== 0) begin n_fail++; $display("FAIL clear_zero: nonzero bytes %0d want 0", nz); end
    step();
  endtask

  task automatic test_load_stall();
    logic [7:0] d;
    logic [7:0] exp_mem [4];
    exp_mem[0] = 8'h05; exp_mem[1] = 8'h06; exp_mem[2] = 8'h07; exp_mem[3] = 8'h00;
    i_ld_valid = 1'b1; i_ld_data = 8'h05; i_ld_last = 1'b0;
    step();
    i_ld_valid = 1'b0; i_ld_data = 8'hEE;
    repeat (10) step();
    read_mem(8'h01, d);
    n_tests++; if (d !== 8'h00) begin n_fail++; $display("FAIL stall_no_write: mem[1] %h want 00", d); end
    n_tests++; if (o_ld_ready !== 1'b1) begin n_fail++; $display("FAIL stall_ready: got %b want 1", o_ld_ready); end
    step();
    i_ld_valid = 1'b1; i_ld_data = 8'h06;
    step();
    i_ld_data = 8'h07; i_ld_last = 1'b1;
    step();
    i_ld_valid = 1'b0; i_ld_last = 1'b0;
    n_tests++; if (o_ld_ready !== 1'b0 || o_cpu_rstn !== 1'b0) begin
      n_fail++; $display("FAIL run_entry: ready %b cpu_rstn %b want 0 0", o_ld_ready, o_cpu_rstn);
    end
    step();
    n_tests++; if (o_cpu_rstn !== 1'b1) begin n_fail++; $display("FAIL cpu_rstn_rise: got %b want 1", o_cpu_rstn); end
    for (int a = 0; a < 4; a++) begin
      read_mem(8'(a), d);
      n_tests++; if (d !== exp_mem[a]) begin n_fail++; $display("FAIL load_mem[%0d]: got %h want %h", a, d, exp_mem[a]); end
    end
    step();
  endtask

  task automatic test_run_write();
    logic [7:0] d;
    i_we = 1'b1; i_waddr = 8'h10; i_wdata = 8'h12;
    step();
    i_we = 1'b0;
    read_mem(8'h10, d);
    n_tests++; if (d !== 8'h12) begin n_fail++; $display("FAIL run_write: mem[10] %h want 12", d); end
    n_tests++; if (o_out_valid !== 1'b0) begin n_fail++; $display("FAIL run_write_nopush: valid %b want 0", o_out_valid); end
    step();
  endtask

  task automatic test_overflow();
    logic [7:0] d;
    i_out_ready = 1'b0;
    for (int k = 0; k < 5; k++) begin
      i_we = 1'b1; i_waddr = 8'hFF; i_wdata = 8'h41 + 8'(k);
      if (k < 4) sb_q.push_back(8'h41 + 8'(k));
      step();
      if (k == 3) begin
        n_tests++; if (o_out_overflow !== 1'b0) begin n_fail++; $display("FAIL ovf_early: got %b want 0", o_out_overflow); end
      end
    end
    i_we = 1'b0;
    n_tests++; if (o_out_overflow !== 1'b1) begin n_fail++; $display("FAIL ovf_set: got %b want 1", o_out_overflow); end
    n_tests++; if (o_out_valid !== 1'b1 || o_out_data !== sb_q[0]) begin
      n_fail++; $display("FAIL fifo_head: valid %b data %h want 1 %h", o_out_valid, o_out_data, sb_q[0]);
    end
    read_mem(8'hFF, d);
    n_tests++; if (d !== 8'h45) begin n_fail++; $display("FAIL ovf_mem: mem[FF] %h want 45", d); end
    step();
  endtask

  task automatic test_full_push_pop();
    logic [7:0] exp;
    i_out_ready = 1'b1; i_we = 1'b1; i_waddr = 8'hFF; i_wdata = 8'h50;
    exp = sb_q.pop_front();
    n_tests++; if (o_out_valid !== 1'b1 || o_out_data !== exp) begin
      n_fail++; $display("FAIL full_pushpop_pop: valid %b data %h want 1 %h", o_out_valid, o_out_data, exp);
    end
    sb_q.push_back(8'h50);
    step();
    i_we = 1'b0;
    n_tests++; if (o_out_overflow !== 1'b1) begin n_fail++; $display("FAIL ovf_sticky: got %b want 1", o_out_overflow); end
    for (int c = 0; c < 10 && sb_q.size() > 0; c++) begin
      if (o_out_valid === 1'b1) begin
        exp = sb_q.pop_front();
        n_tests++; if (o_out_data !== exp) begin n_fail++; $display("FAIL drain: got %h want %h", o_out_data, exp); end
      end
      step();
    end
    n_tests++; if (sb_q.size() !== 0 || o_out_valid !== 1'b0) begin
      n_fail++; $display("FAIL drain_done: left %0d valid %b want 0 0", sb_q.size(), o_out_valid);
    end
  endtask

  task automatic test_back_to_back_empty();
    logic [7:0] exp;
    i_out_ready = 1'b1; i_we = 1'b1; i_waddr = 8'hFF; i_wdata = 8'h60;
    sb_q.push_back(8'h60);
    step();
    i_we = 1'b0; i_out_ready = 1'b0;
    exp = sb_q.pop_front();
    n_tests++; if (o_out_valid !== 1'b1 || o_out_data !== exp) begin
      n_fail++; $display("FAIL empty_pushpop: valid %b data %h want 1 %h", o_out_valid, o_out_data, exp);
    end
    i_out_ready = 1'b1;
    step();
    i_out_ready = 1'b0;
    n_tests++; if (o_out_valid !== 1'b0) begin n_fail++; $display("FAIL single_pop: valid %b want 0", o_out_valid); end
  endtask

  task automatic test_reset_mid_run();
    int bad;
    logic rdy;
    logic [7:0] d;
    i_we = 1'b1; i_waddr = 8'hFF; i_wdata = 8'h77;
    step();
    i_we = 1'b0;
    #1 i_rstn = 1'b0;
    #1;
    n_tests++; if (o_cpu_rstn !== 1'b0 || o_out_valid !== 1'b0 || o_out_overflow !== 1'b0 || o_ld_ready !== 1'b0) begin
      n_fail++; $display("FAIL async_rst: cpu_rstn %b valid %b ovf %b ready %b want 0 0 0 0",
                         o_cpu_rstn, o_out_valid, o_out_overflow, o_ld_ready);
    end
    #1 i_rstn = 1'b1;
    i_we = 1'b1; i_waddr = 8'hFF; i_wdata = 8'h99;
    run_clear(bad, rdy);
    n_tests++; if (bad !== 0 || rdy !== 1'b1) begin
      n_fail++; $display("FAIL reclear: early %0d ready %b want 0 1", bad, rdy);
    end
    step();
    i_we = 1'b0;
    read_mem(8'hFF, d);
    n_tests++; if (d !== 8'h00) begin n_fail++; $display("FAIL we_ignored: mem[FF] %h want 00", d); end
    read_mem(8'h00, d);
    n_tests++; if (d !== 8'h00) begin n_fail++; $display("FAIL reclear_mem0: got %h want 00", d); end
    n_tests++; if (o_cpu_rstn !== 1'b0) begin n_fail++; $display("FAIL load_cpu_rstn: got %b want 0", o_cpu_rstn); end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

  initial begin
    test_reset();
    test_load_stall();
    test_run_write();
    test_overflow();
    test_full_push_pop();
    test_back_to_back_empty();
    test_reset_mid_run();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/subleq_mem.md
SUBLEQ_MEM -- requirements
Module: subleq_mem

Interface
REQ-001 Parameter OUT_ADDR, default 8'hFF, SHALL be the memory-mapped output-port address.
REQ-002 Parameter FIFO_DEPTH, default 4, SHALL be the output FIFO depth; it SHALL be a power of two and at least 2.
REQ-003 i_clk  in  1  SHALL be the sole clock; all state updates on its rising edge.
REQ-004 i_rstn  in  1  SHALL be the reset: asynchronous, active-low.
REQ-005 i_ld_valid / o_ld_ready / i_ld_data[7:0] / i_ld_last  in/out/in/in  SHALL form the program-load byte stream.
REQ-006 i_raddr[7:0] in, o_rdata[7:0] out  SHALL be the CPU read port.
REQ-007 i_waddr[7:0], i_wdata[7:0], i_we  in  SHALL be the CPU write port.
REQ-008 o_cpu_rstn  out  1  SHALL be the synchronous active-low reset for the downstream subleq CPU.
REQ-009 o_out_valid out, i_out_ready in, o_out_data[7:0] out  SHALL form the output byte stream.
REQ-010 o_out_overflow  out  1  SHALL be a sticky flag marking a dropped output byte.

Function
REQ-011 Storage SHALL be a 256x8 array with combinational read, o_rdata = mem[i_raddr], in every state.
REQ-012 Array writes SHALL be synchronous, with at most one write per cycle.
REQ-013 The FSM SHALL have three states: S_CLEAR, S_LOAD and S_RUN.
REQ-014 S_CLEAR SHALL write 0 to addresses 0..255 in order, one address per cycle, using an 8-bit counter.
REQ-015 After the cycle that writes address 255, S_CLEAR SHALL go to S_LOAD; S_CLEAR lasts exactly 256 cycles.
REQ-016 In S_LOAD, o_ld_ready SHALL be 1; each handshake (valid and ready) SHALL write i_ld_data to mem[ld_ptr] and increment ld_ptr, which starts at 0.
REQ-017 S_LOAD SHALL go to S_RUN on the handshake with i_ld_last=1, or on the handshake at ld_ptr=255, whichever comes first.
REQ-018 o_ld_ready SHALL be 0 outside S_LOAD; i_ld_valid SHALL be ignored there.
REQ-019 o_cpu_rstn SHALL be a register that is 0 in S_CLEAR and S_LOAD.
REQ-020 o_cpu_rstn SHALL rise one cycle after S_RUN is entered and stay 1 while in S_RUN.
REQ-021 In S_RUN, i_we=1 SHALL write i_wdata to mem[i_waddr]; i_we SHALL be ignored outside S_RUN.
REQ-022 In S_RUN, i_we=1 with i_waddr==OUT_ADDR SHALL also push i_wdata into the output FIFO.
REQ-023 FIFO read data SHALL be first-word fall-through: o_out_valid = !empty and o_out_data = head entry.
REQ-024 A pop SHALL occur when o_out_valid and i_out_ready are both 1.
REQ-025 A push while full with no pop that cycle SHALL drop the byte, leave the FIFO unchanged and set o_out_overflow.
REQ-026 A simultaneous push and pop while full SHALL succeed, and the count SHALL stay FIFO_DEPTH.
REQ-027 A simultaneous push and pop while empty SHALL not underflow: the pushed byte is stored and count becomes 1.
REQ-028 FIFO pointers SHALL wrap modulo FIFO_DEPTH; the count SHALL range 0..FIFO_DEPTH.
REQ-029 o_out_overflow SHALL clear only on reset.
REQ-030 S_RUN SHALL be terminal; only reset leaves it.

Reset
REQ-031 Asserting i_rstn SHALL immediately force: state S_CLEAR, counters 0, o_cpu_rstn 0, FIFO empty (o_out_valid 0), o_out_overflow 0, o_ld_ready 0.
REQ-032 Reset SHALL take effect from any state, including mid-load and mid-run; the memory array is not reset, because S_CLEAR zeroes it.
REQ-033 On reset release, clearing SHALL restart at address 0.

Verification
REQ-034 Reset release with i_ld_valid=1 -> o_ld_ready stays 0 for 256 cycles, then mem reads back all zeros.
REQ-035 Load 3 bytes 0x05,0x06,0x07 with last on the third byte -> mem[0..2]=05,06,07, mem[3]=00, o_cpu_rstn rises 1 cycle after the third handshake.
REQ-036 Stall test: hold i_ld_valid=0 for 10 cycles mid-load -> no writes; the pointer resumes correctly.
REQ-037 In S_RUN with i_out_ready=0, write 0x41..0x45 to 8'hFF -> FIFO holds 41..44, 0x45 is dropped, o_out_overflow=1, mem[FF]=45.
REQ-038 FIFO full plus push 0x50 with i_out_ready=1 in the same cycle -> 0x41 popped, 0x50 enqueued, o_out_overflow unchanged.
REQ-039 Assert i_rstn=0 mid-run between clock edges -> o_cpu_rstn=0 and o_out_valid=0 before the next edge; release -> 256-cycle clear repeats.
